// File: rtl/mix_sequencer_if.sv
// Master-buffer write port of the mix sequencer: one strobed sample write per frame,
// with a saturation flag that travels alongside the data.
interface mix_sequencer_if #(
  parameter int unsigned IDX_BITS    = 8,
  parameter int unsigned SAMPLE_BITS = 16
);
  logic                          wr_en;
  logic [IDX_BITS-1:0]           wr_addr;
  logic signed [SAMPLE_BITS-1:0] wr_data;
  logic                          clip;

  modport master (output wr_en, output wr_addr, output wr_data, output clip);
  modport slave  (input  wr_en, input  wr_addr, input  wr_data, input  clip);
endinterface

// File: rtl/mix_sequencer.sv
// Per-frame audio mixer: on each LRCLK falling edge, scale and sum every source,
// saturate, and write one sample into the master buffer just behind the player.
module mix_sequencer #(
  parameter int unsigned N_SRC       = 5,
  parameter int unsigned SAMPLE_BITS = 16,
  parameter int unsigned VOLUME_BITS = 8,
  parameter int unsigned BUF_LEN     = 256,
  parameter int unsigned IDX_BITS    = 8
) (
  input  logic                           mclk,
  input  logic                           rst,
  input  logic                           lrclk,
  input  logic [IDX_BITS-1:0]            play_index,
  input  logic [N_SRC*SAMPLE_BITS-1:0]   src_sample,
  input  logic [N_SRC-1:0]               src_valid,
  input  logic [N_SRC*VOLUME_BITS-1:0]   src_vol,
  input  logic                           mute,
  mix_sequencer_if.master                buf_wr,
  output logic                           busy,
  output logic                           overrun
);

  localparam int unsigned PTR_BITS = (N_SRC > 1) ? $clog2(N_SRC) : 1;
  localparam int unsigned ACC_W    = SAMPLE_BITS + $clog2(N_SRC) + 1;
  localparam int unsigned PROD_W   = SAMPLE_BITS + VOLUME_BITS + 1;

  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((2 ** (SAMPLE_BITS - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-(2 ** (SAMPLE_BITS - 1)));

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] CAPT  = 3'd1;
  localparam logic [2:0] ACCUM = 3'd2;
  localparam logic [2:0] SAT   = 3'd3;
  localparam logic [2:0] WRITE = 3'd4;

  logic [2:0] state;
  logic [2:0] state_nxt;

  logic lr_meta;
  logic lr_cur;
  logic lr_prev;
  logic frame_start_c;

  logic signed [SAMPLE_BITS-1:0] sh_sample [N_SRC];
  logic [VOLUME_BITS-1:0]        sh_vol    [N_SRC];
  logic [N_SRC-1:0]              sh_valid;
  logic                          sh_mute;
  logic [IDX_BITS-1:0]           tgt;

  logic [PTR_BITS-1:0]      src_ptr;
  logic signed [ACC_W-1:0]  acc;
  logic signed [PROD_W-1:0] prod_c;
  logic signed [ACC_W-1:0]  term_c;
  logic                     oor_c;
  logic signed [SAMPLE_BITS-1:0] sat_c;

  // lrclk is asynchronous: two flops for metastability, a third for edge detection
  always_ff @(posedge mclk) begin
    if (rst) begin
      lr_meta <= 1'b0;
      lr_cur  <= 1'b0;
      lr_prev <= 1'b0;
    end else begin
      lr_meta <= lrclk;
      lr_cur  <= lr_meta;
      lr_prev <= lr_cur;
    end
  end

  assign frame_start_c = lr_prev & ~lr_cur;

  always_ff @(posedge mclk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (frame_start_c) state_nxt = CAPT;
      CAPT:    state_nxt = ACCUM;
      ACCUM:   if (src_ptr == PTR_BITS'(N_SRC - 1)) state_nxt = SAT;
      SAT:     state_nxt = WRITE;
      WRITE:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // One scaled term per cycle; the arithmetic shift floors toward -inf
  always_comb begin
    prod_c = PROD_W'(sh_sample[src_ptr]) * PROD_W'($signed({1'b0, sh_vol[src_ptr]}));
    term_c = sh_valid[src_ptr] ? ACC_W'(prod_c >>> VOLUME_BITS) : '0;
  end

  always_comb begin
    oor_c = (acc > SAT_MAX) || (acc < SAT_MIN);
    sat_c = SAMPLE_BITS'(acc);
    if (sh_mute)           sat_c = '0;
    else if (acc > SAT_MAX) sat_c = SAMPLE_BITS'(SAT_MAX);
    else if (acc < SAT_MIN) sat_c = SAMPLE_BITS'(SAT_MIN);
  end

  // Shadow copies keep the frame immune to input changes after capture
  always_ff @(posedge mclk) begin
    if (state == CAPT) begin
      for (int unsigned i = 0; i < N_SRC; i++) begin
        sh_sample[i] <= src_sample[i*SAMPLE_BITS +: SAMPLE_BITS];
        sh_vol[i]    <= src_vol[i*VOLUME_BITS +: VOLUME_BITS];
      end
      sh_valid <= src_valid;
      sh_mute  <= mute;
    end
  end

  always_ff @(posedge mclk) begin
    if (rst) begin
      acc     <= '0;
      src_ptr <= '0;
      tgt     <= '0;
    end else begin
      case (state)
        CAPT: begin
          acc     <= '0;
          src_ptr <= '0;
          tgt     <= (play_index == '0) ? IDX_BITS'(BUF_LEN - 1) : play_index - IDX_BITS'(1);
        end
        ACCUM: begin
          acc <= acc + term_c;
          if (src_ptr != PTR_BITS'(N_SRC - 1)) src_ptr <= src_ptr + PTR_BITS'(1);
        end
        default: ;
      endcase
    end
  end

  // Outputs are registered from next-state so they line up with the WRITE cycle
  always_ff @(posedge mclk) begin
    if (rst) begin
      buf_wr.wr_en   <= 1'b0;
      buf_wr.wr_addr <= '0;
      buf_wr.wr_data <= '0;
      buf_wr.clip    <= 1'b0;
      busy           <= 1'b0;
      overrun        <= 1'b0;
    end else begin
      buf_wr.wr_en <= (state_nxt == WRITE);
      buf_wr.clip  <= (state_nxt == WRITE) & ~sh_mute & oor_c;
      if (state_nxt == WRITE) begin
        buf_wr.wr_addr <= tgt;
        buf_wr.wr_data <= sat_c;
      end
      busy <= (state_nxt != IDLE);
      if (frame_start_c && (state != IDLE)) overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mix_sequencer.sv
// Directed and randomized checks of mix_sequencer against an arithmetic mixing model.
module tb_mix_sequencer;

  localparam int unsigned N   = 5;
  localparam int unsigned SB  = 16;
  localparam int unsigned VB  = 8;
  localparam int unsigned IB  = 8;

  logic              mclk = 1'b0;
  logic              rst;
  logic              lrclk;
  logic [IB-1:0]     play_index;
  logic [N*SB-1:0]   src_sample;
  logic [N-1:0]      src_valid;
  logic [N*VB-1:0]   src_vol;
  logic              mute;
  logic              busy;
  logic              overrun;

  int errors = 0;
  int checks = 0;

  mix_sequencer_if #(.IDX_BITS(IB), .SAMPLE_BITS(SB)) buf_wr ();

  mix_sequencer #(
    .N_SRC(N), .SAMPLE_BITS(SB), .VOLUME_BITS(VB), .BUF_LEN(256), .IDX_BITS(IB)
  ) dut (
    .mclk(mclk), .rst(rst), .lrclk(lrclk), .play_index(play_index),
    .src_sample(src_sample), .src_valid(src_valid), .src_vol(src_vol), .mute(mute),
    .buf_wr(buf_wr), .busy(busy), .overrun(overrun)
  );

  always #5 mclk = ~mclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  // Reference: gain is vol/256 with floor rounding, summed exactly, then clamped to int16
  task automatic model(input logic [N*SB-1:0] s, input logic [N-1:0] v,
                       input logic [N*VB-1:0] vo, input logic m,
                       output logic signed [SB-1:0] d, output logic c);
    longint sum = 0;
    for (int i = 0; i < N; i++) begin
      if (v[i]) begin
        longint p;
        p = longint'($signed(s[i*SB +: SB])) * longint'(vo[i*VB +: VB]);
        sum += p >>> 8;
      end
    end
    c = 1'b0;
    if (m)                 d = '0;
    else if (sum > 32767)  begin d = 16'sd32767;  c = 1'b1; end
    else if (sum < -32768) begin d = -16'sd32768; c = 1'b1; end
    else                   d = SB'(sum);
  endtask

  task automatic scramble();
    src_sample = {$urandom, $urandom, $urandom};
    src_valid  = N'($urandom);
    src_vol    = {$urandom, $urandom};
    play_index = IB'($urandom);
    mute       = 1'($urandom);
  endtask

  task automatic run_frame(input string tag, input logic [N*SB-1:0] s, input logic [N-1:0] v,
                           input logic [N*VB-1:0] vo, input logic m, input logic [IB-1:0] pi);
    logic signed [SB-1:0] exp_d;
    logic                 exp_c;
    int                   n;
    model(s, v, vo, m, exp_d, exp_c);
    @(negedge mclk);
    src_sample = s; src_valid = v; src_vol = vo; mute = m; play_index = pi;
    lrclk = 1'b1;
    repeat (3) @(negedge mclk);
    lrclk = 1'b0;
    n = 0;
    while (!busy && n < 10) begin @(negedge mclk); n++; end
    check({tag, "_capt_busy"}, 32'(busy), 32'd1);
    @(negedge mclk);
    scramble();
    n = 1;
    while (!buf_wr.wr_en && n < 20) begin @(negedge mclk); n++; end
    check({tag, "_latency"}, 32'(n), 32'd7);
    check({tag, "_addr"}, 32'(buf_wr.wr_addr), 32'((int'(pi) + 255) % 256));
    check({tag, "_data"}, 32'(buf_wr.wr_data), 32'(exp_d));
    check({tag, "_clip"}, 32'(buf_wr.clip), 32'(exp_c));
    check({tag, "_busy_wr"}, 32'(busy), 32'd1);
    @(negedge mclk);
    check({tag, "_wr_en_off"}, 32'(buf_wr.wr_en), 32'd0);
    check({tag, "_hold"}, 32'(buf_wr.wr_data), 32'(exp_d));
    check({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    logic [N*SB-1:0] s;
    logic [N*VB-1:0] vo;
    int              writes;
    logic [SB-1:0]   wdata;
    logic [IB-1:0]   waddr;

    rst = 1'b1; lrclk = 1'b1; play_index = '0; src_sample = '0;
    src_valid = '0; src_vol = '0; mute = 1'b0;
    repeat (3) @(negedge mclk);
    rst = 1'b0;
    @(negedge mclk);
    check("rst_wr_en",   32'(buf_wr.wr_en),   32'd0);
    check("rst_wr_addr", 32'(buf_wr.wr_addr), 32'd0);
    check("rst_wr_data", 32'(buf_wr.wr_data), 32'd0);
    check("rst_clip",    32'(buf_wr.clip),    32'd0);
    check("rst_busy",    32'(busy),           32'd0);
    check("rst_overrun", 32'(overrun),        32'd0);

    s = '0; s[0 +: SB] = 16'sd1000; vo = '0; vo[0 +: VB] = 8'd128;
    run_frame("half_gain", s, 5'b00001, vo, 1'b0, 8'd10);

    s = '0; s[0 +: SB] = -16'sd2000; vo = '0; vo[0 +: VB] = 8'd255;
    run_frame("wrap_idx", s, 5'b00001, vo, 1'b0, 8'd0);

    s = {5{16'sd30000}};  vo = {5{8'd255}};
    run_frame("sat_pos", s, 5'b11111, vo, 1'b0, 8'd77);
    s = {5{-16'sd30000}};
    run_frame("sat_neg", s, 5'b11111, vo, 1'b0, 8'd200);
    run_frame("mute", s, 5'b11111, vo, 1'b1, 8'd1);
    run_frame("none_valid", s, 5'b00000, vo, 1'b0, 8'd255);
    vo = '0;
    run_frame("zero_vol", s, 5'b11111, vo, 1'b0, 8'd33);

    for (int k = 0; k < 20; k++) begin
      run_frame("rand", {$urandom, $urandom, $urandom}, N'($urandom), {$urandom, $urandom},
                ($urandom_range(7) == 0), IB'($urandom));
    end

    // Second falling edge three cycles into a frame
    @(negedge mclk);
    s = '0; s[0 +: SB] = 16'sd1000; vo = '0; vo[0 +: VB] = 8'd128;
    src_sample = s; src_valid = 5'b00001; src_vol = vo; mute = 1'b0; play_index = 8'd20;
    lrclk = 1'b1;
    repeat (3) @(negedge mclk);
    lrclk = 1'b0;
    @(negedge mclk); lrclk = 1'b1;
    @(negedge mclk);
    @(negedge mclk); lrclk = 1'b0;
    @(negedge mclk); scramble();
    writes = 0; wdata = '0; waddr = '0;
    for (int k = 0; k < 25; k++) begin
      if (buf_wr.wr_en) begin writes++; wdata = buf_wr.wr_data; waddr = buf_wr.wr_addr; end
      @(negedge mclk);
    end
    check("ovr_writes", 32'(writes), 32'd1);
    check("ovr_data",   32'(wdata),  32'd500);
    check("ovr_addr",   32'(waddr),  32'd19);
    check("ovr_flag",   32'(overrun), 32'd1);
    s = '0; s[0 +: SB] = 16'sd1000;
    run_frame("after_ovr", s, 5'b00001, vo, 1'b0, 8'd5);
    check("ovr_sticky", 32'(overrun), 32'd1);

    // Reset during accumulation aborts the frame
    @(negedge mclk);
    src_valid = 5'b11111; src_vol = {5{8'd255}}; src_sample = {5{16'sd30000}};
    lrclk = 1'b1;
    repeat (3) @(negedge mclk);
    lrclk = 1'b0;
    for (int k = 0; k < 10 && !busy; k++) @(negedge mclk);
    check("rstmid_capt", 32'(busy), 32'd1);
    repeat (2) @(negedge mclk);
    rst = 1'b1;
    @(negedge mclk);
    check("rstmid_wr_en",   32'(buf_wr.wr_en), 32'd0);
    check("rstmid_busy",    32'(busy),         32'd0);
    check("rstmid_overrun", 32'(overrun),      32'd0);
    rst = 1'b0;
    writes = 0;
    for (int k = 0; k < 15; k++) begin
      if (buf_wr.wr_en) writes++;
      @(negedge mclk);
    end
    check("rstmid_no_write", 32'(writes), 32'd0);
    run_frame("recover", s, 5'b00001, {5{8'd64}}, 1'b0, 8'd128);
    check("recover_no_ovr", 32'(overrun), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
